// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap controller: hands the renderer a back buffer, flips
// front/back on render completion (optionally deferred to display vsync).
module fb_swap_ctrl #(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 720,
  parameter int ADDR_W     = 21,
  parameter int VSYNC_SWAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              render_done,
  input  logic              disp_vsync,
  output logic              wr_sel,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] rd_base,
  output logic              render_go,
  output logic              render_hold,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt,
  output logic              err_sticky
);

  localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(H_DISP * V_DISP);

  typedef enum logic [1:0] {START, RENDER, PENDING, GO} state_t;

  state_t            state_q;
  logic              wr_sel_q, rd_sel_q, go_q, hold_q, err_q;
  logic [ADDR_W-1:0] wr_base_q, rd_base_q;
  logic [15:0]       frame_q, drop_q;

  logic swap_d, drop_d, err_d;

  // Event decode for the current state; the FSM below consumes these.
  always_comb begin
    swap_d = 1'b0;
    drop_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      START, GO: begin
        drop_d = disp_vsync;
        err_d  = render_done;
      end
      RENDER: begin
        swap_d = render_done && ((VSYNC_SWAP == 0) || disp_vsync);
        drop_d = disp_vsync && !render_done;
      end
      PENDING: begin
        swap_d = disp_vsync;
        err_d  = render_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= START;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b1;
      wr_base_q <= '0;
      rd_base_q <= FRAME;
      go_q      <= 1'b0;
      hold_q    <= 1'b0;
      frame_q   <= '0;
      drop_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      go_q   <= 1'b0;
      hold_q <= 1'b0;
      case (state_q)
        START, GO: begin
          go_q    <= 1'b1;
          state_q <= RENDER;
        end
        RENDER: begin
          if (swap_d)           state_q <= GO;
          else if (render_done) begin
            state_q <= PENDING;
            hold_q  <= 1'b1;
          end
        end
        PENDING: begin
          if (swap_d) state_q <= GO;
          else        hold_q  <= 1'b1;
        end
        default: state_q <= START;
      endcase
      if (swap_d) begin
        wr_sel_q  <= ~wr_sel_q;
        rd_sel_q  <= wr_sel_q;
        wr_base_q <= wr_sel_q ? '0 : FRAME;
        rd_base_q <= wr_sel_q ? FRAME : '0;
        frame_q   <= frame_q + 16'd1;
      end
      if (drop_d && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (err_d) err_q <= 1'b1;
    end
  end

  assign wr_sel      = wr_sel_q;
  assign rd_sel      = rd_sel_q;
  assign wr_base     = wr_base_q;
  assign rd_base     = rd_base_q;
  assign render_go   = go_q;
  assign render_hold = hold_q;
  assign frame_cnt   = frame_q;
  assign drop_cnt    = drop_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Random + directed bench for fb_swap_ctrl: a vsync-deferred instance and an
// immediate-swap instance share stimulus and are each checked against a model.
module tb_fb_swap_ctrl;
  localparam int H = 1280, V = 720, AW = 21;

  logic clk = 1'b0, rst = 1'b1, render_done = 1'b0, disp_vsync = 1'b0;
  always #5 clk = ~clk;

  logic          wr0, rd0, go0, hold0, err0, wr1, rd1, go1, hold1, err1;
  logic [AW-1:0] wb0, rb0, wb1, rb1;
  logic [15:0]   fc0, dc0, fc1, dc1;

  fb_swap_ctrl #(.H_DISP(H), .V_DISP(V), .ADDR_W(AW), .VSYNC_SWAP(1)) dut0 (
    .clk(clk), .rst(rst), .render_done(render_done), .disp_vsync(disp_vsync),
    .wr_sel(wr0), .rd_sel(rd0), .wr_base(wb0), .rd_base(rb0),
    .render_go(go0), .render_hold(hold0), .frame_cnt(fc0), .drop_cnt(dc0),
    .err_sticky(err0));

  fb_swap_ctrl #(.H_DISP(H), .V_DISP(V), .ADDR_W(AW), .VSYNC_SWAP(0)) dut1 (
    .clk(clk), .rst(rst), .render_done(render_done), .disp_vsync(disp_vsync),
    .wr_sel(wr1), .rd_sel(rd1), .wr_base(wb1), .rd_base(rb1),
    .render_go(go1), .render_hold(hold1), .frame_cnt(fc1), .drop_cnt(dc1),
    .err_sticky(err1));

  // Model: "go_owed" = a go pulse is due at the next edge; "hold" doubles as
  // "finished frame waiting for vsync".
  typedef struct {
    bit go_owed; bit hold; bit go; bit wr; int fc; int dc; bit err;
  } m_t;

  m_t m0, m1;
  int n_chk = 0, n_fail = 0;

  function automatic m_t m_reset();
    m_t m;
    m.go_owed = 1; m.hold = 0; m.go = 0; m.wr = 0; m.fc = 0; m.dc = 0; m.err = 0;
    return m;
  endfunction

  function automatic m_t m_step(m_t m, bit done, bit vs, bit defer);
    bit swap = 0, drop = 0;
    if (m.go_owed) begin
      m.go = 1; m.go_owed = 0;
      if (done) m.err = 1;
      drop = vs;
    end else if (m.hold) begin
      m.go = 0;
      if (done) m.err = 1;
      if (vs) begin swap = 1; m.hold = 0; end
    end else begin
      m.go = 0;
      if (done && (!defer || vs)) swap = 1;
      else if (done) m.hold = 1;
      else drop = vs;
    end
    if (swap) begin
      m.wr = !m.wr; m.fc = (m.fc + 1) % 65536; m.go_owed = 1;
    end
    if (drop && m.dc < 65535) m.dc++;
    return m;
  endfunction

  task automatic cmp(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("d0.wr_sel", wr0, m0.wr);         cmp("d0.rd_sel", rd0, !m0.wr);
    cmp("d0.wr_base", wb0, m0.wr * H * V); cmp("d0.rd_base", rb0, (!m0.wr) * H * V);
    cmp("d0.go", go0, m0.go);             cmp("d0.hold", hold0, m0.hold);
    cmp("d0.frame_cnt", fc0, m0.fc);      cmp("d0.drop_cnt", dc0, m0.dc);
    cmp("d0.err", err0, m0.err);
    cmp("d1.wr_sel", wr1, m1.wr);         cmp("d1.rd_sel", rd1, !m1.wr);
    cmp("d1.wr_base", wb1, m1.wr * H * V); cmp("d1.rd_base", rb1, (!m1.wr) * H * V);
    cmp("d1.go", go1, m1.go);             cmp("d1.hold", hold1, m1.hold);
    cmp("d1.frame_cnt", fc1, m1.fc);      cmp("d1.drop_cnt", dc1, m1.dc);
    cmp("d1.err", err1, m1.err);
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next.
  task automatic step(input bit done, input bit vs);
    render_done = done; disp_vsync = vs;
    @(posedge clk);
    m0 = m_step(m0, done, vs, 1'b1);
    m1 = m_step(m1, done, vs, 1'b0);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; render_done = 0; disp_vsync = 0;
    #1;
    m0 = m_reset(); m1 = m_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 0;
  endtask

  initial begin
    m0 = m_reset(); m1 = m_reset();
    @(posedge clk); #1;
    do_reset();
    cmp("lit.rst_rd_base", rb0, 921600);
    cmp("lit.rst_wr_base", wb0, 0);

    // Vsync-deferred swap timeline: done at cycle 10, vsync at cycle 20.
    step(0, 0);
    cmp("lit.first_go", go0, 1);
    for (int i = 2; i < 10; i++) step(0, 0);
    step(1, 0);
    cmp("lit.hold_after_done", hold0, 1);
    cmp("lit.imm_swap_wr", wr1, 1);
    cmp("lit.imm_no_hold", hold1, 0);
    for (int i = 11; i < 20; i++) begin
      step(0, 0);
      cmp("lit.hold_window", hold0, 1);
    end
    step(0, 1);
    cmp("lit.swap_wr_sel", wr0, 1);
    cmp("lit.swap_rd_sel", rd0, 0);
    cmp("lit.swap_wr_base", wb0, 921600);
    cmp("lit.swap_rd_base", rb0, 0);
    cmp("lit.swap_go_not_yet", go0, 0);
    cmp("lit.frame_cnt", fc0, 1);
    step(0, 0);
    cmp("lit.go_after_swap", go0, 1);
    step(0, 0);
    cmp("lit.go_one_cycle", go0, 0);

    // Simultaneous done+vsync in RENDER.
    step(1, 1);
    cmp("lit.sim_swap_wr", wr0, 0);
    cmp("lit.sim_no_drop", dc0, 0);
    step(0, 0);
    cmp("lit.sim_go", go0, 1);

    // Three dropped vsyncs.
    do_reset();
    step(0, 0);
    for (int i = 0; i < 3; i++) step(0, 1);
    cmp("lit.drop3", dc0, 3);
    cmp("lit.drop3_sel", wr0, 0);

    // Error while pending, then reset mid-pending.
    do_reset();
    step(0, 0);
    step(1, 0);
    step(1, 0);
    cmp("lit.err_set", err0, 1);
    cmp("lit.err_no_swap", wr0, 0);
    step(0, 0);
    do_reset();
    cmp("lit.err_cleared", err0, 0);
    cmp("lit.rst_rd_sel", rd0, 1);
    step(0, 0);
    cmp("lit.go_after_rst", go0, 1);
    step(0, 1);
    cmp("lit.no_stale_swap", wr0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 65535 + 5; i++) step(0, 1);
    cmp("lit.drop_sat", dc0, 65535);
    step(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 The block SHALL have parameter H_DISP, default 1280, the horizontal active pixel count.
REQ-002 The block SHALL have parameter V_DISP, default 720, the vertical active line count.
REQ-003 The block SHALL have parameter ADDR_W, default 21, the frame-buffer address width.
REQ-004 The block SHALL have parameter VSYNC_SWAP, default 1: 1 = swap only on display vsync; 0 = swap immediately on render_done.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 render_done  input  1  one-cycle pulse: renderer finished writing the current back buffer.
REQ-008 disp_vsync  input  1  one-cycle pulse: display entering vertical blank.
REQ-009 wr_sel  output  1  index of the back buffer the renderer writes.
REQ-010 rd_sel  output  1  index of the front buffer the display reads.
REQ-011 wr_base  output  ADDR_W  back-buffer base address: wr_sel * H_DISP*V_DISP.
REQ-012 rd_base  output  ADDR_W  front-buffer base address: rd_sel * H_DISP*V_DISP.
REQ-013 render_go  output  1  one-cycle pulse permitting the renderer to start a frame.
REQ-014 render_hold  output  1  level; renderer SHALL stall while high.
REQ-015 frame_cnt  output  16  count of completed swaps, wraps 0xFFFF->0.
REQ-016 drop_cnt  output  16  count of vsyncs with no new frame; saturates at 0xFFFF.
REQ-017 err_sticky  output  1  set when render_done arrives while not in RENDER.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 FSM states SHALL be START, RENDER, PENDING, GO.
REQ-020 START: render_go=1 for exactly one cycle; next state RENDER.
REQ-021 RENDER: render_hold=0; on render_done with VSYNC_SWAP=0 or with disp_vsync in the same cycle -> swap, next state GO.
REQ-022 RENDER: on render_done alone with VSYNC_SWAP=1 -> PENDING, render_hold=1 from the next cycle.
REQ-023 RENDER: on disp_vsync without render_done -> drop_cnt+1 (saturating); state unchanged.
REQ-024 PENDING: render_hold=1; on disp_vsync -> swap, next state GO; other inputs change nothing except REQ-027.
REQ-025 Swap: wr_sel and rd_sel both toggle, frame_cnt+1, wr_base/rd_base update in the same cycle as the selects.
REQ-026 GO: render_go=1 for one cycle, render_hold=0; next state RENDER; render_go is the cycle after the swap edge.
REQ-027 render_done in PENDING or GO SHALL set err_sticky and be otherwise ignored; err_sticky clears only on rst.
REQ-028 disp_vsync in GO or START SHALL increment drop_cnt (saturating).
REQ-029 wr_sel SHALL always equal ~rd_sel.
REQ-030 Base arithmetic SHALL be exact in ADDR_W bits; H_DISP*V_DISP*2 SHALL fit in 2^ADDR_W.

Reset
REQ-031 rst SHALL force state START, wr_sel=0, rd_sel=1, wr_base=0, rd_base=H_DISP*V_DISP, render_go=0, render_hold=0, frame_cnt=0, drop_cnt=0, err_sticky=0.
REQ-032 rst asserted mid-PENDING SHALL abandon the pending swap; no swap occurs after release.
REQ-033 The first edge after rst release SHALL register render_go=1 (state START).

Verification
REQ-034 Reset release, then render_done at cycle 10, disp_vsync at cycle 20 -> render_hold=1 cycles 11-20; wr_sel=1, rd_sel=0, rd_base=0, wr_base=921600 at cycle 21; render_go=1 only at cycle 22; frame_cnt=1.
REQ-035 render_done and disp_vsync in the same cycle while in RENDER -> swap the next edge; render_go one cycle later; drop_cnt unchanged.
REQ-036 Three disp_vsync pulses with no render_done -> drop_cnt=3, selects unchanged; drive 0xFFFF+5 pulses -> drop_cnt holds at 0xFFFF.
REQ-037 VSYNC_SWAP=0: render_done -> swap on the next edge with no vsync required, render_hold never asserted.
REQ-038 Second render_done while PENDING -> err_sticky=1; no extra swap; rst clears it; rst mid-PENDING -> wr_sel=0, rd_sel=1, render_go pulse after release.
